// File: rtl/pixel_compositor_pkg.sv
// rtl/pixel_compositor_pkg.sv - shared tile geometry and selection constants for the pixel compositor
package pixel_compositor_pkg;

    localparam int TILE_X0    = 308;
    localparam int TILE_Y0    = 20;
    localparam int TILE_PITCH = 128;
    localparam int TILE_SPAN  = 99;
    localparam int TILE_COUNT = 12;
    localparam int RGBW       = 24;

    localparam logic [3:0] SEL_NONE = 4'hF;

    // Square ring of thickness w around tile id; corners count as ring.
    function automatic logic ring_hit(input int x, input int y, input logic [3:0] id, input int w);
        int   x0;
        int   y0;
        int   x1;
        int   y1;
        logic in_outer;
        logic in_tile;
        x0       = TILE_X0 + TILE_PITCH * int'(id[1:0]);
        y0       = TILE_Y0 + TILE_PITCH * int'(id[3:2]);
        x1       = x0 + TILE_SPAN - 1;
        y1       = y0 + TILE_SPAN - 1;
        in_outer = (x >= x0 - w) && (x <= x1 + w) && (y >= y0 - w) && (y <= y1 + w);
        in_tile  = (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
        return (int'(id) < TILE_COUNT) && in_outer && !in_tile;
    endfunction

endpackage

// File: rtl/pipe_delay.sv
// rtl/pipe_delay.sv - fixed-depth register delay line with synchronous reset to a constant
module pipe_delay #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RESET_VAL;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign out_data = stage_q[DEPTH-1];

endmodule

// File: rtl/pixel_compositor.sv
// rtl/pixel_compositor.sv - ROM read issue, highlight ring overlay and latency-aligned RGB/sync output
module pixel_compositor
    import pixel_compositor_pkg::*;
#(
    parameter int R_WIDTH            = RGBW / 3,
    parameter int G_WIDTH            = RGBW / 3,
    parameter int B_WIDTH            = RGBW / 3,
    parameter int CNTR_WIDTH_H       = 10,
    parameter int CNTR_WIDTH_V       = 10,
    parameter int ROM_ADDR_BUS_WIDTH = 17,
    parameter int ROM_LATENCY        = 2,
    parameter int H_ACTIVE           = 800,
    parameter int V_ACTIVE           = 480,
    parameter logic [R_WIDTH+G_WIDTH+B_WIDTH-1:0] HILITE_COLOR = 24'hFF0000,
    parameter int HILITE_W           = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [CNTR_WIDTH_H-1:0]              CounterX,
    input  logic [CNTR_WIDTH_V-1:0]              CounterY,
    input  logic                                 hsync_in,
    input  logic                                 vsync_in,
    input  logic                                 isImage,
    input  logic [ROM_ADDR_BUS_WIDTH-1:0]        ROM_Addr,
    input  logic [R_WIDTH+G_WIDTH+B_WIDTH-1:0]   black_white,
    input  logic [3:0]                           sel_id,
    input  logic                                 sel_valid,
    output logic [ROM_ADDR_BUS_WIDTH-1:0]        rom_addr,
    input  logic [R_WIDTH+G_WIDTH+B_WIDTH-1:0]   rom_data,
    output logic [R_WIDTH+G_WIDTH+B_WIDTH-1:0]   rgb,
    output logic                                 hsync,
    output logic                                 vsync,
    output logic                                 blank_n,
    output logic                                 frame_done
);

    localparam int PIX_W = R_WIDTH + G_WIDTH + B_WIDTH;
    localparam int DW    = PIX_W + 6;
    localparam logic [DW-1:0] PIPE_RST = {1'b0, 1'b1, 1'b1, 3'b000, {PIX_W{1'b0}}};

    logic                          hs0_q, hs0_d, vs0_q, vs0_d;
    logic                          act0_q, act0_d, img0_q, img0_d;
    logic                          ring0_q, ring0_d, last0_q, last0_d;
    logic [PIX_W-1:0]              bw0_q, bw0_d;
    logic [ROM_ADDR_BUS_WIDTH-1:0] addr0_q, addr0_d;
    logic [3:0]                    sel_shadow_q, sel_shadow_d, sel_active_q, sel_active_d;
    logic                          vs_fall;

    always_comb begin
        hs0_d   = hsync_in;
        vs0_d   = vsync_in;
        img0_d  = isImage;
        bw0_d   = black_white;
        addr0_d = ROM_Addr;
        act0_d  = (int'(CounterX) < H_ACTIVE) && (int'(CounterY) < V_ACTIVE);
        last0_d = (int'(CounterX) == H_ACTIVE - 1) && (int'(CounterY) == V_ACTIVE - 1);
        ring0_d = ring_hit(int'(CounterX), int'(CounterY), sel_active_q, HILITE_W);
    end

    // Active selection only moves at the frame boundary so the ring never tears mid-frame.
    always_comb begin
        vs_fall      = vs0_q & ~vsync_in;
        sel_shadow_d = sel_valid ? sel_id : sel_shadow_q;
        sel_active_d = sel_active_q;
        if (vs_fall) begin
            sel_active_d = sel_valid ? sel_id : sel_shadow_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs0_q        <= 1'b1;
            vs0_q        <= 1'b1;
            act0_q       <= 1'b0;
            img0_q       <= 1'b0;
            ring0_q      <= 1'b0;
            last0_q      <= 1'b0;
            bw0_q        <= '0;
            addr0_q      <= '0;
            sel_shadow_q <= SEL_NONE;
            sel_active_q <= SEL_NONE;
        end else begin
            hs0_q        <= hs0_d;
            vs0_q        <= vs0_d;
            act0_q       <= act0_d;
            img0_q       <= img0_d;
            ring0_q      <= ring0_d;
            last0_q      <= last0_d;
            bw0_q        <= bw0_d;
            addr0_q      <= addr0_d;
            sel_shadow_q <= sel_shadow_d;
            sel_active_q <= sel_active_d;
        end
    end

    assign rom_addr = addr0_q;

    logic [DW-1:0] pipe_in, pipe_out;

    assign pipe_in = {last0_q, hs0_q, vs0_q, act0_q, img0_q, ring0_q, bw0_q};

    pipe_delay #(
        .WIDTH     (DW),
        .DEPTH     (ROM_LATENCY),
        .RESET_VAL (PIPE_RST)
    ) u_pipe_delay (
        .clk      (clk),
        .rst      (rst),
        .in_data  (pipe_in),
        .out_data (pipe_out)
    );

    logic [PIX_W-1:0] rgb_q, rgb_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d;
    logic             blank_n_q, blank_n_d, frame_done_q, frame_done_d;

    always_comb begin
        hsync_d      = pipe_out[DW-2];
        vsync_d      = pipe_out[DW-3];
        blank_n_d    = pipe_out[DW-4];
        frame_done_d = pipe_out[DW-1] & pipe_out[DW-4];
        if (!pipe_out[DW-4]) begin
            rgb_d = '0;
        end else if (pipe_out[DW-5]) begin
            rgb_d = rom_data;
        end else if (pipe_out[DW-6]) begin
            rgb_d = HILITE_COLOR;
        end else begin
            rgb_d = pipe_out[PIX_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q        <= '0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            blank_n_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            rgb_q        <= rgb_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            blank_n_q    <= blank_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign rgb        = rgb_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign blank_n    = blank_n_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_compositor.sv
// tb/tb_pixel_compositor.sv - directed self-checking bench for pixel_compositor
module tb_pixel_compositor;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  cx, cy;
    logic        hs_in, vs_in, img;
    logic [16:0] addr_in;
    logic [23:0] bw;
    logic [3:0]  sel_id;
    logic        sel_valid;
    logic [16:0] rom_addr;
    logic [23:0] rom_data, rgb;
    logic        hsync, vsync, blank_n, frame_done;
    logic [23:0] rd1, rd2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pixel_compositor dut (
        .clk         (clk),
        .rst         (rst),
        .CounterX    (cx),
        .CounterY    (cy),
        .hsync_in    (hs_in),
        .vsync_in    (vs_in),
        .isImage     (img),
        .ROM_Addr    (addr_in),
        .black_white (bw),
        .sel_id      (sel_id),
        .sel_valid   (sel_valid),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .rgb         (rgb),
        .hsync       (hsync),
        .vsync       (vsync),
        .blank_n     (blank_n),
        .frame_done  (frame_done)
    );

    function automatic logic [23:0] rom_fn(input logic [16:0] a);
        return (a == 17'h00203) ? 24'h12AB34 : ({7'd0, a} ^ 24'hC3C3C3);
    endfunction

    // Two-cycle synchronous ROM model
    always @(posedge clk) begin
        rd1 <= rom_fn(rom_addr);
        rd2 <= rd1;
    end
    assign rom_data = rd2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic filler();
        cx = 10'd900; cy = 10'd500; hs_in = 1'b1; vs_in = 1'b1;
        img = 1'b0; addr_in = 17'h0; bw = 24'h0;
    endtask

    // One pixel followed by blank fillers; checks cycles 1, 3, 4 and 5 after input.
    task automatic run_pix(input string nm, input int x, input int y, input logic hs, input logic vs,
                           input logic im, input logic [16:0] a, input logic [23:0] c,
                           input logic [23:0] e_rgb, input logic e_blank, input logic e_fd);
        cx = x[9:0]; cy = y[9:0]; hs_in = hs; vs_in = vs; img = im; addr_in = a; bw = c;
        tick();
        sel_valid = 1'b0;
        checks++;
        if (rom_addr !== a) begin
            failures++;
            $display("FAIL %s rom_addr got=%h exp=%h", nm, rom_addr, a);
        end
        filler();
        tick();
        tick();
        checks++;
        if ({rgb, blank_n, hsync, vsync, frame_done} !== {24'h0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL %s early rgb=%h blank_n=%b hs=%b vs=%b fd=%b exp blank values",
                     nm, rgb, blank_n, hsync, vsync, frame_done);
        end
        tick();
        checks++;
        if (rgb !== e_rgb) begin
            failures++;
            $display("FAIL %s rgb got=%h exp=%h", nm, rgb, e_rgb);
        end
        checks++;
        if (blank_n !== e_blank) begin
            failures++;
            $display("FAIL %s blank_n got=%b exp=%b", nm, blank_n, e_blank);
        end
        checks++;
        if ({hsync, vsync} !== {hs, vs}) begin
            failures++;
            $display("FAIL %s syncs got=%b%b exp=%b%b", nm, hsync, vsync, hs, vs);
        end
        checks++;
        if (frame_done !== e_fd) begin
            failures++;
            $display("FAIL %s frame_done got=%b exp=%b", nm, frame_done, e_fd);
        end
        tick();
        checks++;
        if ({blank_n, frame_done} !== 2'b00) begin
            failures++;
            $display("FAIL %s late blank_n=%b fd=%b exp=00", nm, blank_n, frame_done);
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++; if (rgb !== 24'h0)       begin failures++; $display("FAIL reset rgb got=%h exp=0", rgb); end
        checks++; if (blank_n !== 1'b0)    begin failures++; $display("FAIL reset blank_n got=%b exp=0", blank_n); end
        checks++; if (hsync !== 1'b1)      begin failures++; $display("FAIL reset hsync got=%b exp=1", hsync); end
        checks++; if (vsync !== 1'b1)      begin failures++; $display("FAIL reset vsync got=%b exp=1", vsync); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset frame_done got=%b exp=0", frame_done); end
        checks++; if (rom_addr !== 17'h0)  begin failures++; $display("FAIL reset rom_addr got=%h exp=0", rom_addr); end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
    endtask

    task automatic test_blank_bw();
        run_pix("bw_active",   100, 100, 1, 1, 0, 17'h0, 24'h5A5A5A, 24'h5A5A5A, 1, 0);
        run_pix("bw_x_edge",   800, 100, 1, 1, 0, 17'h0, 24'h5A5A5A, 24'h000000, 0, 0);
        run_pix("bw_y_edge",   100, 480, 1, 1, 0, 17'h0, 24'h5A5A5A, 24'h000000, 0, 0);
        run_pix("bw_last_col", 799,   0, 1, 1, 0, 17'h0, 24'h010203, 24'h010203, 1, 0);
        run_pix("bw_origin",     0,   0, 1, 1, 0, 17'h0, 24'hFFFFFF, 24'hFFFFFF, 1, 0);
    endtask

    task automatic test_sync_delay();
        run_pix("hsync_low", 200,  10, 0, 1, 0, 17'h0, 24'hABCDEF, 24'hABCDEF, 1, 0);
        run_pix("vsync_low", 900, 500, 1, 0, 0, 17'h0, 24'h000000, 24'h000000, 0, 0);
    endtask

    task automatic test_rom_image();
        run_pix("rom_img", 310, 25, 1, 1, 1, 17'h00203, 24'h0F0F0F, 24'h12AB34, 1, 0);
    endtask

    task automatic test_ring_select();
        sel_id = 4'd5; sel_valid = 1'b1;
        run_pix("sel5_edge",  900, 500, 1, 0, 0, 17'h0, 24'h0, 24'h0, 0, 0);
        run_pix("ring_433",   433, 150, 1, 1, 0, 17'h0, 24'h111111, 24'hFF0000, 1, 0);
        run_pix("noring_432", 432, 150, 1, 1, 0, 17'h0, 24'h111111, 24'h111111, 1, 0);
        run_pix("img_435",    435, 150, 1, 1, 1, 17'h00100, 24'h111111, 24'hC3C2C3, 1, 0);
        run_pix("corner_537", 537, 249, 1, 1, 0, 17'h0, 24'h111111, 24'hFF0000, 1, 0);
        run_pix("noring_538", 538, 249, 1, 1, 0, 17'h0, 24'h111111, 24'h111111, 1, 0);
        run_pix("tile_inner", 436, 148, 1, 1, 0, 17'h0, 24'h111111, 24'h111111, 1, 0);
        run_pix("ring_top",   436, 145, 1, 1, 0, 17'h0, 24'h111111, 24'hFF0000, 1, 0);
        run_pix("noring_144", 436, 144, 1, 1, 0, 17'h0, 24'h111111, 24'h111111, 1, 0);
    endtask

    task automatic test_sel_midframe();
        sel_id = 4'd2; sel_valid = 1'b1;
        run_pix("mid_old_ring", 433, 150, 1, 1, 0, 17'h0, 24'h111111, 24'hFF0000, 1, 0);
        run_pix("mid_no_new",   561,  20, 1, 1, 0, 17'h0, 24'h111111, 24'h111111, 1, 0);
        run_pix("sel2_edge",    900, 500, 1, 0, 0, 17'h0, 24'h0, 24'h0, 0, 0);
        run_pix("new_ring",     561,  20, 1, 1, 0, 17'h0, 24'h111111, 24'hFF0000, 1, 0);
        run_pix("old_gone",     433, 150, 1, 1, 0, 17'h0, 24'h111111, 24'h111111, 1, 0);
    endtask

    task automatic test_sel_coincident();
        sel_id = 4'd0; sel_valid = 1'b1;
        run_pix("sel0_edge",    900, 500, 1, 0, 0, 17'h0, 24'h0, 24'h0, 0, 0);
        run_pix("sel0_ring",    305, 117, 1, 1, 0, 17'h0, 24'h111111, 24'hFF0000, 1, 0);
        run_pix("sel0_not_sh2", 561,  20, 1, 1, 0, 17'h0, 24'h111111, 24'h111111, 1, 0);
    endtask

    task automatic test_none_frame_done();
        sel_id = 4'd13; sel_valid = 1'b1;
        run_pix("sel13_edge",  900, 500, 1, 0, 0, 17'h0, 24'h0, 24'h0, 0, 0);
        run_pix("none_305",    305, 117, 1, 1, 0, 17'h0, 24'h444444, 24'h444444, 1, 0);
        run_pix("none_tile13", 433, 410, 1, 1, 0, 17'h0, 24'h444444, 24'h444444, 1, 0);
        run_pix("fd_last",     799, 479, 1, 1, 0, 17'h0, 24'h333333, 24'h333333, 1, 1);
        run_pix("fd_798",      798, 479, 1, 1, 0, 17'h0, 24'h333333, 24'h333333, 1, 0);
        run_pix("fd_478",      799, 478, 1, 1, 0, 17'h0, 24'h333333, 24'h333333, 1, 0);
    endtask

    task automatic test_reset_midframe();
        sel_id = 4'd5; sel_valid = 1'b1;
        run_pix("rst_sel5_edge", 900, 500, 1, 0, 0, 17'h0, 24'h0, 24'h0, 0, 0);
        cx = 10'd400; cy = 10'd200; img = 1'b0; addr_in = 17'h1ABCD; bw = 24'h777777;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if ({rgb, blank_n} !== {24'h777777, 1'b1}) begin
            failures++;
            $display("FAIL rst_pre rgb=%h blank_n=%b exp 777777/1", rgb, blank_n);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({rgb, blank_n, hsync, vsync, frame_done, rom_addr} !== {24'h0, 1'b0, 1'b1, 1'b1, 1'b0, 17'h0}) begin
                failures++;
                $display("FAIL rst_hold cyc=%0d rgb=%h blank_n=%b hs=%b vs=%b fd=%b rom_addr=%h exp reset values",
                         i, rgb, blank_n, hsync, vsync, frame_done, rom_addr);
            end
        end
        rst = 1'b0;
        cx = 10'd433; cy = 10'd150; addr_in = 17'h0; bw = 24'h222222;
        tick();
        filler();
        for (int i = 1; i <= 3; i++) begin
            checks++;
            if (blank_n !== 1'b0) begin
                failures++;
                $display("FAIL rst_stale cyc=%0d blank_n got=%b exp=0", i, blank_n);
            end
            tick();
        end
        checks++;
        if ({rgb, blank_n} !== {24'h222222, 1'b1}) begin
            failures++;
            $display("FAIL rst_first_pix rgb=%h blank_n=%b exp 222222/1", rgb, blank_n);
        end
        for (int i = 0; i < 4; i++) tick();
    endtask

    initial begin
        rst = 1'b1;
        sel_id = 4'd0;
        sel_valid = 1'b0;
        filler();
        test_reset();
        test_blank_bw();
        test_sync_delay();
        test_rom_image();
        test_ring_select();
        test_sel_midframe();
        test_sel_coincident();
        test_none_frame_done();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
